// File: rtl/mult_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// mult_ctrl_pkg
//
// Shared definitions for the HI/LO multiply sequencing controller:
//   - state_t        : controller FSM states (IDLE, START, WAIT)
//   - W_DEF          : default operand width (product and HI:LO are 2*W)
//   - TIMEOUT_CYCLES_DEF : default watchdog limit, in WAIT cycles
//   - cnt_width()    : width of a counter that spans 0 .. limit-1
//   - CNT_W_DEF      : watchdog counter width for the default limit
//
// Optional feature macro used by the users of this package: MULT_TIMEOUT_EN.
// ----------------------------------------------------------------------------
package mult_ctrl_pkg;

    localparam int W_DEF              = 16;
    localparam int TIMEOUT_CYCLES_DEF = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    // Bits needed to count 0 .. limit-1; never narrower than one bit.
    function automatic int cnt_width(input int limit);
        if (limit < 2) begin
            return 1;
        end
        else begin
            return $clog2(limit);
        end
    endfunction

    localparam int CNT_W_DEF = cnt_width(TIMEOUT_CYCLES_DEF);

endpackage

// File: rtl/mult_watchdog.sv
// ----------------------------------------------------------------------------
// mult_watchdog
//
// Counts consecutive cycles spent waiting for the multiplier. The count
// restarts whenever count_en drops. expire is asserted during the
// TIMEOUT_CYCLES-th consecutive enabled cycle, so the controller can leave
// WAIT on that cycle's edge.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   count_en  in   controller is in WAIT this cycle
//   expire    out  this is the last permitted WAIT cycle
//
// Only instantiated when MULT_TIMEOUT_EN is defined.
// ----------------------------------------------------------------------------
module mult_watchdog
    import mult_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic count_en,
    output logic expire
);

    localparam int             CNT_W = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_r;

    // Wait-cycle counter: saturates at LAST, cleared whenever not waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end
        else if (!count_en) begin
            cnt_r <= {CNT_W{1'b0}};
        end
        else if (cnt_r != LAST) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        else begin
            cnt_r <= cnt_r;
        end
    end

    assign expire = count_en & (cnt_r == LAST);

endmodule

// File: rtl/mult_hilo_ctrl.sv
// ----------------------------------------------------------------------------
// mult_hilo_ctrl
//
// Gives the pipeline access to the shared shift-add multiplier. A MULT
// request is accepted in IDLE (mult_ack pulse, operands latched), the
// multiplier is started for exactly one cycle (START), and the controller
// then waits (WAIT) for done1 before capturing produto into HI/LO.
// MFHI/MFLO/MTHI/MTLO are served from IDLE; while a multiply is in flight
// any HI/LO access stalls the pipeline and MTHI/MTLO are not applied.
//
// Ports:
//   clk, rst              clock / asynchronous active-high reset
//   mult_req, mult_a/b    multiply request and operands (held until ack)
//   mult_ack              one-cycle acceptance pulse
//   mf_hi, mf_lo          read HI / LO (mf_hi wins), data on rd_data
//   mt_hi, mt_lo, wr_data write HI / LO
//   rd_data               combinational read data
//   stall                 hold the current HI/LO instruction
//   busy                  multiply in flight
//   err                   sticky watchdog timeout flag
//   St, mndo, mdor        start pulse and operands to the multiplier
//   done1, produto        multiplier completion level and product
//
// Optional feature: define MULT_TIMEOUT_EN to add a WAIT watchdog that
// abandons a multiply after TIMEOUT_CYCLES WAIT cycles and sets err.
// Without it, err is tied low and WAIT lasts until done1.
// ----------------------------------------------------------------------------
module mult_hilo_ctrl
    import mult_ctrl_pkg::*;
#(
    parameter int W              = W_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           mult_req,
    input  logic [W-1:0]   mult_a,
    input  logic [W-1:0]   mult_b,
    output logic           mult_ack,
    input  logic           mf_hi,
    input  logic           mf_lo,
    input  logic           mt_hi,
    input  logic           mt_lo,
    input  logic [W-1:0]   wr_data,
    output logic [W-1:0]   rd_data,
    output logic           stall,
    output logic           busy,
    output logic           err,
    output logic           St,
    output logic [W-1:0]   mndo,
    output logic [W-1:0]   mdor,
    input  logic           done1,
    input  logic [2*W-1:0] produto
);

    // Reject nonsensical configurations at elaboration time.
    if (W < 1 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("mult_hilo_ctrl: W must be >= 1 and TIMEOUT_CYCLES >= 2");
    end

    state_t         state_r;
    state_t         state_s;
    logic           accept_s;
    logic           capture_s;
    logic           expire_s;
    logic           hilo_op_s;
    logic [W-1:0]   hi_r;
    logic [W-1:0]   lo_r;
    logic [W-1:0]   mndo_r;
    logic [W-1:0]   mdor_r;

`ifdef MULT_TIMEOUT_EN
    logic           timeout_s;
    logic           err_r;

    mult_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .count_en (state_r == WAIT),
        .expire   (expire_s)
    );

    // done1 on the expiring cycle still wins: the product is captured.
    assign timeout_s = (state_r == WAIT) & ~done1 & expire_s;

    // Sticky timeout flag; a fresh acceptance starts a clean operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r <= 1'b0;
        end
        else if (accept_s) begin
            err_r <= 1'b0;
        end
        else if (timeout_s) begin
            err_r <= 1'b1;
        end
        else begin
            err_r <= err_r;
        end
    end

    assign err = err_r;
`else
    assign expire_s = 1'b0;
    assign err      = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end
        else begin
            state_r <= state_s;
        end
    end

    // Next-state and transfer strobes. done1 is only meaningful in WAIT:
    // in IDLE/START it may still be high from the previous operation.
    always_comb begin
        state_s   = state_r;
        accept_s  = 1'b0;
        capture_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (mult_req) begin
                    accept_s = 1'b1;
                    state_s  = START;
                end
                else begin
                    state_s  = IDLE;
                end
            end
            START: begin
                state_s = WAIT;
            end
            WAIT: begin
                if (done1) begin
                    capture_s = 1'b1;
                    state_s   = IDLE;
                end
                else if (expire_s) begin
                    state_s   = IDLE;
                end
                else begin
                    state_s   = WAIT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Operand latches toward the multiplier; stable for the whole operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mndo_r <= {W{1'b0}};
            mdor_r <= {W{1'b0}};
        end
        else if (accept_s) begin
            mndo_r <= mult_a;
            mdor_r <= mult_b;
        end
        else begin
            mndo_r <= mndo_r;
            mdor_r <= mdor_r;
        end
    end

    // Architectural HI/LO. Moves are honoured only in IDLE, including the
    // cycle a multiply is accepted (the product overwrites them later).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_r <= {W{1'b0}};
            lo_r <= {W{1'b0}};
        end
        else if (capture_s) begin
            hi_r <= produto[2*W-1:W];
            lo_r <= produto[W-1:0];
        end
        else if (state_r == IDLE) begin
            if (mt_hi) begin
                hi_r <= wr_data;
            end
            if (mt_lo) begin
                lo_r <= wr_data;
            end
        end
        else begin
            hi_r <= hi_r;
            lo_r <= lo_r;
        end
    end

    assign hilo_op_s = mf_hi | mf_lo | mt_hi | mt_lo;

    assign mult_ack  = accept_s;
    assign St        = (state_r == START);
    assign busy      = (state_r != IDLE);
    assign stall     = busy & hilo_op_s;
    assign mndo      = mndo_r;
    assign mdor      = mdor_r;
    assign rd_data   = mf_hi ? hi_r : lo_r;

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mult_hilo_ctrl
//
// Scoreboard bench. The stimulus process issues multiplies and HI/LO moves,
// keeps an architectural HI/LO reference and pushes expected operands and
// read data into queues. A behavioural multiplier answers St with a random
// latency and may leave done1 high afterwards (stale level). A monitor
// samples every falling edge, pops expectations when the DUT presents them
// and checks the handshake against the cycle rules of the controller.
// ----------------------------------------------------------------------------
module tb_mult_hilo_ctrl;

    localparam int W  = 16;
    localparam int TO = 64;

    logic           clk;
    logic           rst;
    logic           mult_req;
    logic [W-1:0]   mult_a;
    logic [W-1:0]   mult_b;
    logic           mult_ack;
    logic           mf_hi;
    logic           mf_lo;
    logic           mt_hi;
    logic           mt_lo;
    logic [W-1:0]   wr_data;
    logic [W-1:0]   rd_data;
    logic           stall;
    logic           busy;
    logic           err;
    logic           St;
    logic [W-1:0]   mndo;
    logic [W-1:0]   mdor;
    logic           done1;
    logic [2*W-1:0] produto;

    int errors = 0;
    int checks = 0;

    logic [W-1:0]   rd_q[$];
    logic [2*W-1:0] op_q[$];
    int             lat_q[$];

    logic           real_done;
    logic           tb_busy;
    logic           tb_start;
    logic           tb_err;
    int             tb_wc;
    logic [W-1:0]   cur_a;
    logic [W-1:0]   cur_b;
    logic [W-1:0]   ref_hi;
    logic [W-1:0]   ref_lo;

    mult_hilo_ctrl #(.W(W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .mult_req(mult_req), .mult_a(mult_a), .mult_b(mult_b), .mult_ack(mult_ack),
        .mf_hi(mf_hi), .mf_lo(mf_lo), .mt_hi(mt_hi), .mt_lo(mt_lo),
        .wr_data(wr_data), .rd_data(rd_data), .stall(stall), .busy(busy), .err(err),
        .St(St), .mndo(mndo), .mdor(mdor), .done1(done1), .produto(produto)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [2*W-1:0] mul(input logic [W-1:0] a, input logic [W-1:0] b);
        return (2*W)'(a) * (2*W)'(b);
    endfunction

    // Behavioural multiplier: answers St after lat cycles (lat 0 = never).
    initial begin
        logic [W-1:0] a, b;
        int           lat;
        done1 = 1'b0; produto = '0; real_done = 1'b0;
        forever begin
            @(negedge clk);
            if (St && !rst) begin
                a = mndo; b = mdor;
                lat = (lat_q.size() > 0) ? lat_q.pop_front() : 1;
                @(posedge clk); #1;
                done1 = 1'b0;
                if (lat > 0) begin
                    for (int i = 1; i < lat; i++) begin
                        @(posedge clk); #1;
                    end
                    done1 = 1'b1; produto = mul(a, b); real_done = 1'b1;
                    @(posedge clk); #1;
                    real_done = 1'b0;
                    if ($urandom_range(0, 1) == 1) produto = (2*W)'($urandom);
                    else                          done1 = 1'b0;
                end
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        logic           exp_ack;
        logic           any_op;
        logic [2*W-1:0] pair;
        tb_busy = 1'b0; tb_start = 1'b0; tb_err = 1'b0; tb_wc = 0; cur_a = '0; cur_b = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                tb_busy = 1'b0; tb_start = 1'b0; tb_err = 1'b0; tb_wc = 0;
                cur_a = '0; cur_b = '0;
                op_q.delete();
            end
            else begin
                exp_ack = mult_req & ~tb_busy;
                any_op  = mf_hi | mf_lo | mt_hi | mt_lo;
                chk("mult_ack", mult_ack, exp_ack);
                chk("busy", busy, tb_busy);
                chk("St", St, tb_start);
                chk("stall", stall, tb_busy & any_op);
                chk("err", err, tb_err);
                if (tb_start) begin
                    if (op_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL op_queue: start cycle with no accepted request at %0t", $time);
                    end
                    else begin
                        pair  = op_q.pop_front();
                        cur_a = pair[2*W-1:W];
                        cur_b = pair[W-1:0];
                    end
                end
                chk("mndo", mndo, cur_a);
                chk("mdor", mdor, cur_b);
                if ((mf_hi | mf_lo) && !stall) begin
                    if (rd_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL rd_queue: read completed with rd_data=0x%0h but none expected at %0t", rd_data, $time);
                    end
                    else begin
                        chk("rd_data", rd_data, rd_q.pop_front());
                    end
                end
                if (exp_ack) begin
                    tb_busy = 1'b1; tb_start = 1'b1; tb_err = 1'b0; tb_wc = 0;
                end
                else if (tb_start) begin
                    tb_start = 1'b0;
                end
                else if (tb_busy) begin
                    if (real_done) begin
                        tb_busy = 1'b0;
                    end
                    else begin
                        tb_wc++;
`ifdef MULT_TIMEOUT_EN
                        if (tb_wc == TO) begin
                            tb_busy = 1'b0; tb_err = 1'b1;
                        end
`endif
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input int lat);
        bit got = 1'b0;
        mult_req = 1'b1; mult_a = a; mult_b = b;
        lat_q.push_back(lat);
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (mult_ack) got = 1'b1;
        end
        if (got) op_q.push_back({a, b});
        else begin
            checks++; errors++;
            $display("FAIL ack_timeout: no mult_ack within 300 cycles at %0t", $time);
        end
        tick();
        mult_req = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (!busy) ok = 1'b1;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL idle_timeout: busy still high after 300 cycles at %0t", $time);
        end
        tick();
    endtask

    task automatic wait_nostall();
        bit ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (!stall) ok = 1'b1;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL stall_timeout: stall still high after 300 cycles at %0t", $time);
        end
        tick();
    endtask

    task automatic rd(input logic sel_hi, input logic [W-1:0] exp);
        mf_hi = sel_hi; mf_lo = ~sel_hi;
        rd_q.push_back(exp);
        tick();
        mf_hi = 1'b0; mf_lo = 1'b0;
    endtask

    task automatic wr(input logic sel_hi, input logic [W-1:0] d);
        mt_hi = sel_hi; mt_lo = ~sel_hi; wr_data = d;
        tick();
        mt_hi = 1'b0; mt_lo = 1'b0;
        if (sel_hi) ref_hi = d;
        else        ref_lo = d;
    endtask

    // One multiply plus an optional overlapping HI/LO access, then readback.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int lat, input int mode);
        logic [2*W-1:0] p;
        logic [W-1:0]   d;
        logic           sel;
        p   = mul(a, b);
        d   = W'($urandom);
        sel = 1'($urandom_range(0, 1));
        case (mode)
            1: begin
                mf_hi = sel; mf_lo = ~sel;
                rd_q.push_back(sel ? ref_hi : ref_lo);
                issue(a, b, lat);
                mf_hi = 1'b0; mf_lo = 1'b0;
            end
            2: begin
                mt_hi = sel; mt_lo = ~sel; wr_data = d;
                issue(a, b, lat);
                mt_hi = 1'b0; mt_lo = 1'b0;
            end
            3: begin
                issue(a, b, lat);
                tick();
                mf_hi = sel; mf_lo = ~sel;
                rd_q.push_back(sel ? p[2*W-1:W] : p[W-1:0]);
                wait_nostall();
                mf_hi = 1'b0; mf_lo = 1'b0;
            end
            4: begin
                issue(a, b, lat);
                tick();
                mt_hi = sel; mt_lo = ~sel; wr_data = d;
                wait_nostall();
                mt_hi = 1'b0; mt_lo = 1'b0;
            end
            5: begin
                logic [W-1:0] a2, b2;
                a2 = W'($urandom); b2 = W'($urandom);
                issue(a, b, lat);
                p = mul(a2, b2);
                issue(a2, b2, $urandom_range(1, 6));
            end
            default: begin
                issue(a, b, lat);
            end
        endcase
        wait_idle();
        ref_hi = p[2*W-1:W];
        ref_lo = p[W-1:0];
        if (mode == 4) begin
            if (sel) ref_hi = d;
            else     ref_lo = d;
        end
        rd(1'b1, ref_hi);
        rd(1'b0, ref_lo);
    endtask

    // Global time bound.
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "time bound exceeded");
    end

    // Stimulus.
    initial begin
        rst = 1'b1; mult_req = 1'b0; mult_a = '0; mult_b = '0;
        mf_hi = 1'b0; mf_lo = 1'b0; mt_hi = 1'b0; mt_lo = 1'b0; wr_data = '0;
        ref_hi = '0; ref_lo = '0;
        repeat (3) tick();
        @(negedge clk);
        chk("reset_St", St, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_mndo", mndo, 16'h0000);
        chk("reset_err", err, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        rd(1'b1, 16'h0000);
        rd(1'b0, 16'h0000);

        // 0xF * 0xF with done1 on cycle 20.
        run_op(16'h000F, 16'h000F, 19, 0);
        // Full-scale operands.
        run_op(16'hFFFF, 16'hFFFF, 5, 0);
        // MTHI in IDLE.
        wr(1'b1, 16'h1234);
        rd(1'b1, 16'h1234);
        rd(1'b0, ref_lo);
        // MFLO held through WAIT, MTLO held through WAIT.
        run_op(16'h1234, 16'h5678, 6, 3);
        run_op(16'h0BAD, 16'hCAFE, 5, 4);
        // Same-cycle request with read, then with write.
        run_op(16'h0102, 16'h0304, 3, 1);
        run_op(16'h00FF, 16'h0100, 4, 2);

        // Reset in WAIT: product discarded, late done1 ignored.
        issue(16'hABCD, 16'h0123, 12);
        tick(); tick();
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_St", St, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_mdor", mdor, 16'h0000);
        tick();
        rst = 1'b0;
        ref_hi = '0; ref_lo = '0;
        repeat (15) tick();
        wait_idle();
        rd(1'b1, 16'h0000);
        rd(1'b0, 16'h0000);

        // Randomized operations.
        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] a, b;
            int mode;
            a = W'($urandom); b = W'($urandom);
            if ($urandom_range(0, 7) == 0) a = 16'hFFFF;
            if ($urandom_range(0, 7) == 0) b = 16'h0000;
            mode = $urandom_range(0, 5);
            run_op(a, b, (mode == 0) ? $urandom_range(1, 10) : $urandom_range(3, 10), mode);
            if ($urandom_range(0, 3) == 0) wr(1'($urandom_range(0, 1)), W'($urandom));
        end

`ifdef MULT_TIMEOUT_EN
        // done1 never arrives: abandon after TO WAIT cycles, HI/LO kept.
        issue(16'h4321, 16'h8765, 0);
        wait_idle();
        rd(1'b1, ref_hi);
        rd(1'b0, ref_lo);
        run_op(16'h0003, 16'h0005, 3, 0);
`endif

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_hilo_ctrl.md
# mult_hilo_ctrl

Sequencing controller that gives the MIPS pipeline access to the shared 16x16 shift-add multiplier. It accepts MULT requests, drives the multiplier's start/operand inputs, waits for completion, and captures the 32-bit product into architectural HI/LO registers. It serves MFHI/MFLO/MTHI/MTLO and stalls the pipeline while a multiply is in flight.

## Interface
Parameters:
- W, 16, operand width; product and HI:LO are 2*W.
- TIMEOUT_CYCLES, 64, watchdog limit in WAIT cycles (used only with MULT_TIMEOUT_EN).

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- mult_req  in  1  pipeline requests a multiply; held until mult_ack.
- mult_a, mult_b  in  W  operands, valid with mult_req.
- mult_ack  out  1  one-cycle pulse: request accepted.
- mf_hi, mf_lo  in  1  read HI / LO this cycle.
- mt_hi, mt_lo  in  1  write wr_data into HI / LO.
- wr_data  in  W  MTHI/MTLO data.
- rd_data  out  W  combinational read data.
- stall  out  1  pipeline must hold the current HI/LO instruction.
- busy  out  1  multiply in flight (state != IDLE).
- err  out  1  sticky timeout flag.
- St  out  1  start to multiplier.
- mndo, mdor  out  W  multiplicand/multiplier to multiplier.
- done1  in  1  multiplier completion (level).
- produto  in  2*W  multiplier product.

## Operation
- FSM states: IDLE, START, WAIT.
- IDLE: if mult_req, latch mult_a->mndo, mult_b->mdor, pulse mult_ack, go START. Otherwise service mt_hi/mt_lo (write on edge).
- START: St=1 for exactly this cycle; done1 ignored (may be stale from a prior op); go WAIT.
- WAIT: St=0; mndo/mdor held stable. On done1=1: HI<=produto[2W-1:W], LO<=produto[W-1:0], go IDLE.
- rd_data = mf_hi ? HI : LO (mf_hi wins if both asserted).
- stall = busy & (mf_hi | mf_lo | mt_hi | mt_lo). mt_* while busy are not applied.
- mult_req while busy: not acked, held by pipeline, accepted on the return to IDLE.
- Same-cycle mult_req and mf_* in IDLE: read returns pre-multiply HI/LO, no stall.
- Same-cycle mult_req and mt_* in IDLE: mt write is applied; the multiply later overwrites HI/LO.
- done1 outside WAIT: ignored.

## Timing
- Reset values: state IDLE; St=0, mndo=mdor=0, HI=LO=0, mult_ack=0, busy=0, stall=0, err=0.
- Cycle 0: mult_req seen in IDLE, mult_ack=1. Cycle 1: St=1. Cycle 2 onward: WAIT.
- done1 at cycle k (k>=2): HI/LO visible at cycle k+1; busy=0 at cycle k+1; the next mult_ack is possible at cycle k+1.
- rst asserted mid-operation: immediate return to reset values; the product in flight is discarded.

## Configuration
- MULT_TIMEOUT_EN defined: a counter increments each WAIT cycle. On reaching TIMEOUT_CYCLES without done1, the FSM goes to IDLE, HI/LO are unchanged, and err=1 (sticky). err clears on reset or the next mult_ack.
- Undefined: WAIT persists until done1; err tied to 0; no counter logic.

## Structure
- Package mult_ctrl_pkg: state enum (IDLE, START, WAIT), W default, TIMEOUT_CYCLES default, counter width.
- Sub-module mult_watchdog (counter + expire output), instantiated only under MULT_TIMEOUT_EN.

## Test plan
- mult_a=0x000F, mult_b=0x000F, model done1 at cycle 20 with produto=0x000000E1 -> St high one cycle only; after completion HI=0x0000, LO=0x00E1; busy drops the cycle after done1.
- 0xFFFF*0xFFFF, produto=0xFFFE0001 -> HI=0xFFFE, LO=0x0001; mf_hi gives rd_data=0xFFFE, mf_lo gives 0x0001.
- mf_lo asserted during WAIT -> stall=1 until done1 handled, then rd_data equals the new LO with stall=0.
- mt_hi wr_data=0x1234 in IDLE -> HI=0x1234; mt_lo during WAIT -> stall=1 and LO unchanged.
- rst pulsed during WAIT -> St=0, HI=LO=0, busy=0; a late done1 is ignored.
- MULT_TIMEOUT_EN, done1 never asserted -> after 64 WAIT cycles err=1, busy=0, HI/LO unchanged; the next mult_ack clears err.
